// File: rtl/mpc_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mpc_seq_pkg : shared types, Q7 constants and saturation for the sequencer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mpc_seq_pkg;

  localparam int W = 21;

  localparam int Q7_FRAC_BITS = 7;
  localparam int Q7_ONE       = 1 << Q7_FRAC_BITS;
  localparam int Q7_U_LIMIT   = 100 * Q7_ONE;

  // Saturation runs at a fixed wide width so any W up to SAT_W can share it.
  localparam int SAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } seq_state_t;

  function automatic logic signed [SAT_W-1:0] sat_w(
    input logic signed [SAT_W-1:0] x,
    input logic signed [SAT_W-1:0] lo,
    input logic signed [SAT_W-1:0] hi
  );
    if (x > hi)      sat_w = hi;
    else if (x < lo) sat_w = lo;
    else             sat_w = x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpc_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mpc_tick_gen : control-period tick, one pulse every PERIOD_CYC cycles     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mpc_tick_gen #(
  parameter int PERIOD_CYC = 1000
) (
  input  logic clk_1,
  input  logic ap_rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

  logic [CW-1:0] cnt;

  // Held at zero while disabled so the first tick lands PERIOD_CYC cycles after en rises.
  always_ff @(posedge clk_1 or posedge ap_rst) begin
    if (ap_rst)                   cnt <= '0;
    else if (!en || cnt == LAST)  cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

  assign tick = en && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/mpc_sample_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mpc_sample_sequencer : periodic operand latch, core launch/wait, clamped  |
// | actuator capture. Option macro MPC_SEQ_FAILSAFE_EN: zero u_out on timeout |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mpc_sample_sequencer
  import mpc_seq_pkg::*;
#(
  parameter int                 W           = mpc_seq_pkg::W,
  parameter int                 PERIOD_CYC  = 1000,
  parameter int                 TIMEOUT_CYC = 800,
  parameter logic signed [W-1:0] U_MAX      = 21'sd12800,
  parameter logic signed [W-1:0] U_MIN      = -21'sd12800
) (
  input  logic                clk_1,
  input  logic                ap_rst,
  input  logic                en,
  input  logic signed [W-1:0] r_in,
  input  logic signed [W-1:0] pos_in,
  input  logic signed [W-1:0] vel_in,
  output logic signed [W-1:0] r,
  output logic signed [W-1:0] pos,
  output logic signed [W-1:0] vel,
  output logic                ap_start,
  output logic                fc0_input_ap_vld,
  input  logic                ap_done,
  input  logic                ap_idle,
  input  logic signed [W-1:0] layer13_out,
  output logic signed [W-1:0] u_out,
  output logic                u_valid,
  output logic                busy,
  output logic                timeout_flag,
  output logic [15:0]         overrun_cnt
);

  localparam int WCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);

  seq_state_t               state;
  logic [WCW-1:0]           wait_cnt;
  logic                     tick;
  logic                     drop_tick;
  logic signed [SAT_W-1:0]  sat_res;

  mpc_tick_gen #(
    .PERIOD_CYC (PERIOD_CYC)
  ) u_tick_gen (
    .clk_1  (clk_1),
    .ap_rst (ap_rst),
    .en     (en),
    .tick   (tick)
  );

  // A tick is lost when the sequencer is mid-transaction or the core is not idle.
  assign drop_tick = tick && ((state != ST_IDLE) || !ap_idle);

  assign sat_res = sat_w(SAT_W'(layer13_out), SAT_W'(U_MIN), SAT_W'(U_MAX));

  always_ff @(posedge clk_1 or posedge ap_rst) begin
    if (ap_rst) begin
      state            <= ST_IDLE;
      wait_cnt         <= '0;
      r                <= '0;
      pos              <= '0;
      vel              <= '0;
      ap_start         <= 1'b0;
      fc0_input_ap_vld <= 1'b0;
      u_out            <= '0;
      u_valid          <= 1'b0;
      busy             <= 1'b0;
      timeout_flag     <= 1'b0;
      overrun_cnt      <= '0;
    end else begin
      ap_start         <= 1'b0;
      fc0_input_ap_vld <= 1'b0;
      u_valid          <= 1'b0;

      if (drop_tick && (overrun_cnt != 16'hFFFF))
        overrun_cnt <= overrun_cnt + 16'd1;

      case (state)
        ST_IDLE: begin
          if (tick && ap_idle) begin
            r                <= r_in;
            pos              <= pos_in;
            vel              <= vel_in;
            ap_start         <= 1'b1;
            fc0_input_ap_vld <= 1'b1;
            busy             <= 1'b1;
            state            <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          wait_cnt <= wait_cnt + WCW'(1);
          if (ap_done) begin
            busy  <= 1'b0;
            state <= ST_CAPTURE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_flag <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_IDLE;
`ifdef MPC_SEQ_FAILSAFE_EN
            u_out        <= '0;
            u_valid      <= 1'b1;
`endif
          end
        end

        ST_CAPTURE: begin
          u_out   <= sat_res[W-1:0];
          u_valid <= 1'b1;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mpc_sample_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mpc_sample_sequencer : directed vectors with a u_out scoreboard        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mpc_sample_sequencer;

  localparam int W       = 21;
  localparam int PERIOD  = 20;
  localparam int TIMEOUT = 12;

  logic                clk_1 = 1'b0;
  logic                ap_rst = 1'b1;
  logic                en = 1'b0;
  logic signed [W-1:0] r_in = '0, pos_in = '0, vel_in = '0;
  logic                ap_done = 1'b0;
  logic                ap_idle = 1'b1;
  logic signed [W-1:0] layer13_out = '0;
  logic signed [W-1:0] r, pos, vel, u_out;
  logic                ap_start, fc0_input_ap_vld, u_valid, busy, timeout_flag;
  logic [15:0]         overrun_cnt;

  mpc_sample_sequencer #(
    .W           (W),
    .PERIOD_CYC  (PERIOD),
    .TIMEOUT_CYC (TIMEOUT),
    .U_MAX       (21'sd12800),
    .U_MIN       (-21'sd12800)
  ) dut (
    .clk_1            (clk_1),
    .ap_rst           (ap_rst),
    .en               (en),
    .r_in             (r_in),
    .pos_in           (pos_in),
    .vel_in           (vel_in),
    .r                (r),
    .pos              (pos),
    .vel              (vel),
    .ap_start         (ap_start),
    .fc0_input_ap_vld (fc0_input_ap_vld),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .layer13_out      (layer13_out),
    .u_out            (u_out),
    .u_valid          (u_valid),
    .busy             (busy),
    .timeout_flag     (timeout_flag),
    .overrun_cnt      (overrun_cnt)
  );

  always #5 clk_1 = ~clk_1;

  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  int     start_cnt = 0;
  int     core_delay = 6;
  longint core_result = 0;
  longint exp_q[$];
  logic   prev_start = 1'b0;

  always @(posedge clk_1) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Core model: answers each ap_start after core_delay cycles; 0 means never.
  initial begin
    forever begin : core_loop
      automatic int d;
      @(negedge clk_1);
      if (ap_start && !ap_rst) begin
        d = core_delay;
        if (d > 0) begin
          repeat (d) @(negedge clk_1);
          layer13_out = W'(core_result);
          ap_done = 1'b1;
          @(negedge clk_1);
          ap_done = 1'b0;
        end
      end
    end
  end

  // Monitor: launch-pulse shape and u_out scoreboard.
  always @(negedge clk_1) begin
    if (ap_start) begin
      start_cnt++;
      check("ap_start_single_cycle", prev_start, 0);
      check("fc0_vld_with_start", fc0_input_ap_vld, 1);
      check("busy_in_launch", busy, 1);
    end else if (fc0_input_ap_vld) begin
      check("fc0_vld_without_start", fc0_input_ap_vld, 0);
    end
    prev_start = ap_start;
    if (u_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL u_valid_unexpected: u_valid=1 u_out=%0d with no expected entry (cycle %0d)", u_out, cyc);
      end else begin
        check("u_out", u_out, exp_q.pop_front());
      end
    end
  end

  task automatic wait_start(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk_1);
      n++;
    end while (!ap_start && n < bound);
    if (!ap_start) begin
      vectors++;
      miscompares++;
      $display("FAIL launch_wait: ap_start=0 after %0d cycles, required a launch", bound);
    end
  endtask

  task automatic wait_uvalid(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk_1);
      n++;
    end while (!u_valid && n < bound);
    if (!u_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL u_valid_wait: u_valid=0 after %0d cycles, required a strobe", bound);
    end
  endtask

  task automatic txn(input longint res, input longint exp, output int lat, output int start_c);
    int n;
    core_delay  = 6;
    core_result = res;
    exp_q.push_back(exp);
    wait_start(60, lat);
    start_c = cyc;
    wait_uvalid(20, n);
    check("u_valid_latency", n, 8);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_r"}, r, 0);
    check({tag, "_pos"}, pos, 0);
    check({tag, "_vel"}, vel, 0);
    check({tag, "_u_out"}, u_out, 0);
    check({tag, "_u_valid"}, u_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout_flag"}, timeout_flag, 0);
    check({tag, "_overrun_cnt"}, overrun_cnt, 0);
    check({tag, "_ap_start"}, ap_start, 0);
    check({tag, "_fc0_vld"}, fc0_input_ap_vld, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s0, s1, n, starts_before;

    // Reset state
    repeat (2) @(negedge clk_1);
    check_all_zero("reset");

    // 1: nominal transaction, latch and period
    r_in = 100; pos_in = -5; vel_in = 3;
    ap_rst = 1'b0;
    en = 1'b1;
    txn(640, 640, lat, s0);
    check("first_launch_latency", lat, PERIOD);
    check("r_latched", r, 100);
    check("pos_latched", pos, -5);
    check("vel_latched", vel, 3);
    r_in = 7; pos_in = 8; vel_in = 9;
    txn(640, 640, lat, s1);
    check("launch_period", s1 - s0, PERIOD);
    check("r_relatched", r, 7);
    check("busy_after_capture", busy, 0);

    // 2: saturation
    txn(20000, 12800, lat, s0);
    txn(-20000, -12800, lat, s0);
    txn(12800, 12800, lat, s0);
    txn(-12801, -12800, lat, s0);
    txn(-100, -100, lat, s0);
    check("no_overrun_nominal", overrun_cnt, 0);
    check("no_timeout_nominal", timeout_flag, 0);

    // 3: timeout with en dropped mid-transaction, then a late ap_done
    core_delay = 0;
`ifdef MPC_SEQ_FAILSAFE_EN
    exp_q.push_back(0);
`endif
    wait_start(40, lat);
    en = 1'b0;
    repeat (TIMEOUT) @(negedge clk_1);
    check("timeout_flag_before", timeout_flag, 0);
    check("busy_in_wait", busy, 1);
    @(negedge clk_1);
    check("timeout_flag_set", timeout_flag, 1);
    check("busy_after_timeout", busy, 0);
`ifdef MPC_SEQ_FAILSAFE_EN
    check("u_out_failsafe", u_out, 0);
`else
    check("u_out_hold", u_out, -100);
`endif
    starts_before = start_cnt;
    layer13_out = 555;
    ap_done = 1'b1;
    @(negedge clk_1);
    ap_done = 1'b0;
    repeat (40) @(negedge clk_1);
`ifdef MPC_SEQ_FAILSAFE_EN
    check("u_out_after_late_done", u_out, 0);
`else
    check("u_out_after_late_done", u_out, -100);
`endif
    check("no_launch_en_low", start_cnt - starts_before, 0);
    check("timeout_flag_sticky", timeout_flag, 1);

    // 4: overruns while core busy
    ap_idle = 1'b0;
    en = 1'b1;
    starts_before = start_cnt;
    repeat (3 * PERIOD) @(negedge clk_1);
    check("overrun_cnt_3", overrun_cnt, 3);
    check("no_launch_core_busy", start_cnt - starts_before, 0);
    ap_idle = 1'b1;
    txn(1234, 1234, lat, s0);
    check("launch_after_idle", lat, PERIOD);
    check("overrun_cnt_stable", overrun_cnt, 3);

    // 6: reset during WAIT, late ap_done from the aborted transaction
    core_delay = 8;
    wait_start(40, lat);
    repeat (4) @(negedge clk_1);
    ap_rst = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk_1);
    // 5: ap_done coincident with the timeout cycle
    core_delay  = TIMEOUT;
    core_result = 300;
    exp_q.push_back(300);
    ap_rst = 1'b0;
    wait_start(40, lat);
    check("launch_after_reset", lat, PERIOD);
    wait_uvalid(30, n);
    check("u_valid_latency_edge", n, TIMEOUT + 2);
    check("timeout_flag_capture_wins", timeout_flag, 0);
    check("overrun_after_reset", overrun_cnt, 0);

    en = 1'b0;
    repeat (5) @(negedge clk_1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
